pll_lock_supervisor: RTL

//  Supervises the system PLL from the free-running 50 MHz reference clock.

---
 rtl/pll_lock_supervisor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the free-running reference clock; holds the fabric in reset until lock is qualified.
// Optional build macro PLL_SUP_GLITCH_FILTER_EN: in RUN, tolerate locked_s drops shorter than GLITCH_CYCLES.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 5000,
    parameter int GLITCH_CYCLES       = 4,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] relock_cnt
);

    typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [7:0]             relock_cnt_q, relock_cnt_d;
    logic                   locked_s;
    logic                   lock_loss;
    logic                   restart;

    // Elaboration-time parameter sanity: an illegal setting leaves a visible empty scope.
    if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1) begin : g_bad_params
    end

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};
    assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_SUP_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic [GW-1:0] glitch_q, glitch_d;

    // Dedicated drop counter so the main cycle counter stays free in RUN.
    always_comb begin
        glitch_d  = '0;
        lock_loss = 1'b0;
        if (state_q == RUN && !locked_s) begin
            if (glitch_q == GW'(GLITCH_CYCLES - 1)) begin
                lock_loss = 1'b1;
            end else begin
                glitch_d = glitch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end
`else
    assign lock_loss = !locked_s;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pll_rst_d    = pll_rst_q;
        sys_rst_n_d  = sys_rst_n_q;
        ready_d      = ready_q;
        lock_lost_d  = 1'b0;
        relock_cnt_d = relock_cnt_q;
        restart      = 1'b0;

        if (state_q != RESET_PLL && force_relock) begin
            restart = 1'b1;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state_d   = WAIT_LOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        restart = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d     = RUN;
                        cnt_d       = '0;
                        sys_rst_n_d = 1'b1;
                        ready_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (lock_loss) begin
                        restart     = 1'b1;
                        lock_lost_d = 1'b1;
                    end
                end
                default: state_d = RESET_PLL;
            endcase
        end

        // Every PLL restart funnels through here so the count and reset outputs stay consistent.
        if (restart) begin
            state_d     = RESET_PLL;
            cnt_d       = '0;
            pll_rst_d   = 1'b1;
            sys_rst_n_d = 1'b0;
            ready_d     = 1'b0;
            if (relock_cnt_q != 8'hFF) begin
                relock_cnt_d = relock_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            sync_q       <= '0;
            pll_rst_q    <= 1'b1;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            relock_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_q       <= sync_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_n_q  <= sys_rst_n_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign relock_cnt = relock_cnt_q;

endmodule
